// File: rtl/secded_pkg.sv
`default_nettype none
// ============================================================================
// Module      : secded_pkg
// Description : Shared types and constants for the SECDED (16,11) decode engine
// Revision    : 1.0 - initial release
// ============================================================================
package secded_pkg;

    // Engine sequencing states
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD_LO = 3'd1,
        RD_HI = 3'd2,
        DEC   = 3'd3,
        WR_LO = 3'd4,
        WR_HI = 3'd5,
        DONE  = 3'd6
    } state_t;

    // Data bit positions inside the codeword (Hamming position == bit index)
    localparam int POS_D1  = 3;
    localparam int POS_D2  = 5;
    localparam int POS_D4  = 7;
    localparam int POS_D5  = 9;
    localparam int POS_D11 = 15;

    // Default memory map
    localparam int DEF_SRC_BASE  = 64;
    localparam int DEF_DST_BASE  = 94;
    localparam int DEF_NUM_WORDS = 15;

    // Bit of the decoded word that flags an uncorrectable error
    localparam int DBL_FLAG_BIT = 15;

    // Gather the 11 message bits out of a codeword, d1 landing in bit 0
    function automatic logic [10:0] extract_data(input logic [15:0] cw);
        return {cw[POS_D11:POS_D5], cw[POS_D4:POS_D2], cw[POS_D1]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/secded_dec.sv
`default_nettype none
// ============================================================================
// Module      : secded_dec
// Description : Combinational SECDED (16,11) codeword decoder
// Revision    : 1.0 - initial release
// ============================================================================
module secded_dec
    import secded_pkg::*;
(
    input  logic [15:0] cw,
    output logic [10:0] data,
    output logic        single,
    output logic        double
);

    logic [3:0]  syn;
    logic        parity;
    logic [15:0] fixed;

    // Syndrome, overall parity, single-bit repair and message extraction
    always_comb begin
        syn = 4'd0;
        for (int k = 1; k < 16; k++) begin
            if (cw[k]) begin
                syn = syn ^ 4'(k);
            end
        end
        parity = ^cw;
        // A nonzero syndrome with odd parity points at the one flipped bit;
        // with even parity (double error) the word is passed through untouched.
        fixed = cw;
        if ((syn != 4'd0) && parity) begin
            fixed[syn] = ~cw[syn];
        end
        single = parity;
        double = (syn != 4'd0) && !parity;
        data   = extract_data(fixed);
    end

endmodule
`default_nettype wire

// File: rtl/secded_decode_engine.sv
`default_nettype none
// ============================================================================
// Module      : secded_decode_engine
// Description : Memory-mapped SECDED (16,11) decode engine; reads codewords,
//               corrects/flags errors, writes decoded words back, pulses ack
// Revision    : 1.0 - initial release
// ============================================================================
module secded_decode_engine
    import secded_pkg::*;
#(
    parameter int SRC_BASE  = DEF_SRC_BASE,
    parameter int DST_BASE  = DEF_DST_BASE,
    parameter int NUM_WORDS = DEF_NUM_WORDS,
    parameter int AW        = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req,
    output logic          ack,
    output logic [AW-1:0] mem_addr,
    input  logic [7:0]    mem_rd_data,
    output logic          mem_wr_en,
    output logic [7:0]    mem_wr_data,
    output logic [7:0]    err_single_cnt,
    output logic [7:0]    err_double_cnt
);

    localparam logic [6:0]    LAST_IDX = 7'(NUM_WORDS - 1);
    localparam logic [AW-1:0] SRC_LO   = AW'(SRC_BASE);
    localparam logic [AW-1:0] SRC_HI   = AW'(SRC_BASE + 1);
    localparam logic [AW-1:0] DST_LO   = AW'(DST_BASE);
    localparam logic [AW-1:0] DST_HI   = AW'(DST_BASE + 1);

    state_t        state, state_n;
    logic [6:0]    idx, idx_n;
    logic [AW-1:0] off_n;
    logic [7:0]    lo_byte, hi_byte, word_hi;
    logic [10:0]   dec_data;
    logic          dec_single, dec_double;
    logic [15:0]   dec_word;

    secded_dec u_dec (
        .cw     ({hi_byte, lo_byte}),
        .data   (dec_data),
        .single (dec_single),
        .double (dec_double)
    );

    // Byte offset of the word being addressed next; wraps modulo 2^AW
    assign off_n = AW'({idx_n, 1'b0});

    // Decoded word with the double-error flag in its dedicated bit
    always_comb begin
        dec_word               = {5'b0, dec_data};
        dec_word[DBL_FLAG_BIT] = dec_double;
    end

    // State and word index registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            idx   <= 7'd0;
        end else begin
            state <= state_n;
            idx   <= idx_n;
        end
    end

    // Next-state and next-index logic
    always_comb begin
        state_n = state;
        idx_n   = idx;
        case (state)
            IDLE: begin
                if (req) begin
                    state_n = RD_LO;
                    idx_n   = 7'd0;
                end
            end
            RD_LO: state_n = RD_HI;
            RD_HI: state_n = DEC;
            DEC:   state_n = WR_LO;
            WR_LO: state_n = WR_HI;
            WR_HI: begin
                if (idx == LAST_IDX) begin
                    state_n = DONE;
                end else begin
                    idx_n   = idx + 7'd1;
                    state_n = RD_LO;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Registered bus outputs, derived from the state being entered
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ack         <= 1'b0;
            mem_wr_en   <= 1'b0;
            mem_addr    <= '0;
            mem_wr_data <= 8'd0;
        end else begin
            ack       <= (state_n == DONE);
            mem_wr_en <= (state_n == WR_LO) || (state_n == WR_HI);
            case (state_n)
                RD_LO:   mem_addr <= SRC_LO + off_n;
                RD_HI:   mem_addr <= SRC_HI + off_n;
                WR_LO:   mem_addr <= DST_LO + off_n;
                WR_HI:   mem_addr <= DST_HI + off_n;
                default: mem_addr <= mem_addr;
            endcase
            if (state == DEC) begin
                mem_wr_data <= dec_word[7:0];
            end else if (state == WR_LO) begin
                mem_wr_data <= word_hi;
            end
        end
    end

    // Codeword capture, decoded high byte and saturating error counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lo_byte        <= 8'd0;
            hi_byte        <= 8'd0;
            word_hi        <= 8'd0;
            err_single_cnt <= 8'd0;
            err_double_cnt <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        err_single_cnt <= 8'd0;
                        err_double_cnt <= 8'd0;
                    end
                end
                RD_LO: lo_byte <= mem_rd_data;
                RD_HI: hi_byte <= mem_rd_data;
                DEC: begin
                    word_hi <= dec_word[15:8];
                    if (dec_single && (err_single_cnt != 8'hFF)) begin
                        err_single_cnt <= err_single_cnt + 8'd1;
                    end
                    if (dec_double && (err_double_cnt != 8'hFF)) begin
                        err_double_cnt <= err_double_cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_secded_decode_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_secded_decode_engine
// Description : Scoreboard bench for the SECDED (16,11) decode engine
// Revision    : 1.0 - initial release
// ============================================================================
module tb_secded_decode_engine;

    localparam int SRC = 64;
    localparam int DST = 94;
    localparam int NW  = 15;
    localparam int AW  = 8;

    logic          clk;
    logic          reset;
    logic          req;
    logic          ack;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_rd_data;
    logic          mem_wr_en;
    logic [7:0]    mem_wr_data;
    logic [7:0]    err_single_cnt;
    logic [7:0]    err_double_cnt;

    logic [7:0] src_mem [256];

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;

    secded_decode_engine #(
        .SRC_BASE  (SRC),
        .DST_BASE  (DST),
        .NUM_WORDS (NW),
        .AW        (AW)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .req            (req),
        .ack            (ack),
        .mem_addr       (mem_addr),
        .mem_rd_data    (mem_rd_data),
        .mem_wr_en      (mem_wr_en),
        .mem_wr_data    (mem_wr_data),
        .err_single_cnt (err_single_cnt),
        .err_double_cnt (err_double_cnt)
    );

    // Combinational read port of the data memory
    assign mem_rd_data = src_mem[mem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference encoder: places message bits, then computes each parity bit
    function automatic logic [15:0] encode(input logic [10:0] d);
        logic [15:0] c;
        c        = 16'd0;
        c[3]     = d[0];
        c[7:5]   = d[3:1];
        c[15:9]  = d[10:4];
        c[1]     = c[3] ^ c[5] ^ c[7] ^ c[9] ^ c[11] ^ c[13] ^ c[15];
        c[2]     = c[3] ^ c[6] ^ c[7] ^ c[10] ^ c[11] ^ c[14] ^ c[15];
        c[4]     = c[5] ^ c[6] ^ c[7] ^ c[12] ^ c[13] ^ c[14] ^ c[15];
        c[8]     = ^c[15:9];
        c[0]     = ^c[15:1];
        return c;
    endfunction

    function automatic logic [10:0] extract(input logic [15:0] c);
        return {c[15:9], c[7:5], c[3]};
    endfunction

    task automatic load_word(input int i, input logic [15:0] cw);
        src_mem[8'(SRC + 2*i)]     = cw[7:0];
        src_mem[8'(SRC + 2*i + 1)] = cw[15:8];
    endtask

    task automatic push_exp(input int i, input logic [15:0] w);
        exp_q.push_back('{addr: 8'(DST + 2*i),     data: w[7:0]});
        exp_q.push_back('{addr: 8'(DST + 2*i + 1), data: w[15:8]});
    endtask

    // Launch one run (or two with req held), score every write, check timing and counters
    task automatic run(input string name, input bit hold, input bit busy, input int n_runs,
                       input int exp_s, input int exp_d);
        int  k, acks, a1, a2, extra;
        wr_t e;
        k = 0; acks = 0; a1 = 0; a2 = 0; extra = 0;
        @(negedge clk);
        req = 1'b1;
        while (acks < n_runs && k < 400) begin
            @(negedge clk);
            k++;
            if (!hold && k == 1) req = 1'b0;
            if (busy && k == 10) req = 1'b1;
            if (busy && k == 11) req = 1'b0;
            if (hold && acks == 1 && k == a1 + 3) req = 1'b0;
            if (mem_wr_en) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL %s write: got addr=%0d data=0x%02h, expected no write", name, mem_addr, mem_wr_data);
                end else begin
                    e = exp_q.pop_front();
                    if (mem_addr !== e.addr || mem_wr_data !== e.data) begin
                        n_fail++;
                        $display("FAIL %s write: got addr=%0d data=0x%02h, expected addr=%0d data=0x%02h",
                                 name, mem_addr, mem_wr_data, e.addr, e.data);
                    end
                end
            end
            if (ack) begin
                acks++;
                if (acks == 1) a1 = k; else a2 = k;
            end
        end
        req = 1'b0;
        n_checks++;
        if (acks != n_runs) begin
            n_fail++;
            $display("FAIL %s ack_count: got %0d acks within bound, expected %0d", name, acks, n_runs);
        end
        n_checks++;
        if (a1 != 5*NW + 1) begin
            n_fail++;
            $display("FAIL %s latency: got ack at cycle %0d, expected %0d", name, a1, 5*NW + 1);
        end
        if (n_runs == 2) begin
            n_checks++;
            if (a2 - a1 != 5*NW + 2) begin
                n_fail++;
                $display("FAIL %s restart_gap: got %0d cycles, expected %0d", name, a2 - a1, 5*NW + 2);
            end
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s missing_writes: got %0d outstanding, expected 0", name, exp_q.size());
        end
        // Quiet period: no further ack or write, counters hold their values
        repeat (8) begin
            @(negedge clk);
            if (ack || mem_wr_en) extra++;
        end
        n_checks++;
        if (extra != 0) begin
            n_fail++;
            $display("FAIL %s quiet_after_done: got %0d active cycles, expected 0", name, extra);
        end
        n_checks++;
        if (err_single_cnt !== 8'(exp_s) || err_double_cnt !== 8'(exp_d)) begin
            n_fail++;
            $display("FAIL %s counters: got single=%0d double=%0d, expected single=%0d double=%0d",
                     name, err_single_cnt, err_double_cnt, exp_s, exp_d);
        end
        exp_q.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req   = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (ack !== 1'b0 || mem_wr_en !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_strobes: got ack=%b wr_en=%b, expected 0/0", ack, mem_wr_en);
        end
        n_checks++;
        if (mem_addr !== 8'd0 || mem_wr_data !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_bus: got addr=%0d data=0x%02h, expected 0/0x00", mem_addr, mem_wr_data);
        end
        n_checks++;
        if (err_single_cnt !== 8'd0 || err_double_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_counters: got %0d/%0d, expected 0/0", err_single_cnt, err_double_cnt);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_all_ones();
        for (int i = 0; i < NW; i++) begin
            load_word(i, 16'hFFFF);
            push_exp(i, 16'h07FF);
        end
        run("all_ones", 1'b0, 1'b0, 1, 0, 0);
    endtask

    task automatic test_directed();
        logic [10:0] d;
        load_word(0, 16'h1000); push_exp(0, 16'h0000);
        load_word(1, 16'h0001); push_exp(1, 16'h0000);
        load_word(2, 16'hFDF7); push_exp(2, 16'h87EE);
        for (int i = 3; i < NW; i++) begin
            d = 11'($urandom_range(0, 2047));
            load_word(i, encode(d));
            push_exp(i, {5'b0, d});
        end
        run("directed", 1'b0, 1'b0, 1, 2, 1);
    endtask

    task automatic test_single_sweep();
        logic [10:0] d;
        logic [15:0] cw;
        for (int b = 0; b < 16; b++) begin
            for (int i = 0; i < NW; i++) begin
                d     = 11'($urandom_range(0, 2047));
                cw    = encode(d);
                cw[b] = ~cw[b];
                load_word(i, cw);
                push_exp(i, {5'b0, d});
            end
            run($sformatf("single_bit%0d", b), 1'b0, 1'b0, 1, NW, 0);
        end
    endtask

    task automatic test_double();
        logic [10:0] d;
        logic [15:0] cw;
        int          b1, b2;
        for (int i = 0; i < NW; i++) begin
            d  = 11'($urandom_range(0, 2047));
            cw = encode(d);
            b1 = $urandom_range(0, 15);
            b2 = (b1 + 1 + $urandom_range(0, 14)) % 16;
            cw[b1] = ~cw[b1];
            cw[b2] = ~cw[b2];
            load_word(i, cw);
            push_exp(i, {1'b1, 4'b0, extract(cw)});
        end
        run("double", 1'b0, 1'b0, 1, 0, NW);
    endtask

    task automatic test_reset_mid_run();
        logic [10:0] d;
        logic [15:0] cw;
        int          acks, wrs;
        acks = 0; wrs = 0;
        for (int i = 0; i < NW; i++) begin
            d  = 11'($urandom_range(0, 2047));
            cw = encode(d);
            cw[i] = ~cw[i];
            load_word(i, cw);
        end
        @(negedge clk); req = 1'b1;
        @(negedge clk); req = 1'b0;
        repeat (19) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if (ack !== 1'b0 || mem_wr_en !== 1'b0 || mem_addr !== 8'd0 || mem_wr_data !== 8'd0) begin
            n_fail++;
            $display("FAIL midrun_reset_bus: got ack=%b wr_en=%b addr=%0d data=0x%02h, expected all 0",
                     ack, mem_wr_en, mem_addr, mem_wr_data);
        end
        n_checks++;
        if (err_single_cnt !== 8'd0 || err_double_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL midrun_reset_counters: got %0d/%0d, expected 0/0", err_single_cnt, err_double_cnt);
        end
        repeat (4) begin
            @(negedge clk);
            if (ack) acks++;
        end
        reset = 1'b0;
        repeat (100) begin
            @(negedge clk);
            if (ack) acks++;
            if (mem_wr_en) wrs++;
        end
        n_checks++;
        if (acks != 0 || wrs != 0) begin
            n_fail++;
            $display("FAIL midrun_no_ack: got acks=%0d writes=%0d, expected 0/0", acks, wrs);
        end
        // Fresh run with a stray req pulse while busy
        for (int i = 0; i < NW; i++) begin
            d  = 11'($urandom_range(0, 2047));
            cw = encode(d);
            cw[(i + 5) % 16] = ~cw[(i + 5) % 16];
            load_word(i, cw);
            push_exp(i, {5'b0, d});
        end
        run("after_reset_busy_req", 1'b0, 1'b1, 1, NW, 0);
    endtask

    task automatic test_back_to_back();
        logic [10:0] d;
        logic [15:0] ex [NW];
        for (int i = 0; i < NW; i++) begin
            d = 11'($urandom_range(0, 2047));
            load_word(i, encode(d));
            ex[i] = {5'b0, d};
            push_exp(i, ex[i]);
        end
        for (int i = 0; i < NW; i++) begin
            push_exp(i, ex[i]);
        end
        run("back_to_back", 1'b1, 1'b0, 2, 0, 0);
    endtask

    initial begin
        for (int a = 0; a < 256; a++) src_mem[a] = 8'd0;
        test_reset();
        test_all_ones();
        test_directed();
        test_single_sweep();
        test_double();
        test_reset_mid_run();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
